mmio_arbiter: RTL and testbench

//   Shares the byte-serial MMIO port of ctrlr (new_data/din/dout) between NUM_REQ

---
 rtl/mmio_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mmio_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// -----------------------------------------------------------------------------
// mmio_arbiter
//   Shares the byte-serial MMIO port of the ctrlr register block between
//   NUM_REQ on-chip requesters. A round-robin arbiter grants one pending
//   request. The FSM then drives a two-byte frame on the port:
//     byte 1: {rd, addr[6:0]}   (rd = 1 for a read)
//     byte 2: write data, or 0x00 as a dummy byte for a read
//   The byte returned by ctrlr (reads) or 0x00 (writes) goes back to the
//   granted requester with a one-cycle rsp_valid pulse.
//
// Parameters
//   NUM_REQ     number of requesters (2..4)
//   GAP_CYCLES  idle cycles (new_data=0) after each byte beat (1..7)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   [NUM_REQ]   requester i has a pending transaction
//   req_write  in   [NUM_REQ]   1 = write, 0 = read
//   req_addr   in   [7*NUM_REQ] register address, slice [7i+6:7i]
//   req_wdata  in   [8*NUM_REQ] write data, slice [8i+7:8i]
//   req_ready  out  [NUM_REQ]   one-hot pulse: request i accepted
//   rsp_valid  out  [NUM_REQ]   one-hot pulse: transaction i complete
//   rsp_rdata  out  [8]         read data while rsp_valid != 0 (0x00 for writes)
//   busy       out              high in every state except IDLE
//   new_data   out              byte strobe to ctrlr
//   din        out  [8]         byte to ctrlr
//   dout       in   [8]         byte from ctrlr
// -----------------------------------------------------------------------------
module mmio_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   busy,
  output logic                   new_data,
  output logic [7:0]             din,
  input  logic [7:0]             dout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [2:0]    GAP_LAST = 3'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] PTR_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    CMD_GAP,
    DATA,
    DATA_GAP,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;        // last granted requester
  logic [IW-1:0] gnt;        // requester owning the current frame
  logic          lat_write;
  logic [7:0]    lat_wdata;
  logic [2:0]    gap_cnt;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          any_valid;

  // Round-robin search starting at ptr+1. The loop runs from the lowest
  // priority candidate (ptr itself) up to the highest (ptr+1), so the last
  // hit is the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    pick      = ptr;
    cand      = ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick      = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Acceptance is a same-cycle handshake. Gating with rst keeps the pulse
  // quiet while the block is held in reset, even though state reads IDLE.
  always_comb begin
    req_ready = '0;
    if (rst && (state == IDLE) && any_valid)
      req_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= PTR_INIT;
      gnt       <= '0;
      lat_write <= 1'b0;
      lat_wdata <= 8'h00;
      gap_cnt   <= 3'd0;
      new_data  <= 1'b0;
      din       <= 8'h00;
      rsp_valid <= '0;
      rsp_rdata <= 8'h00;
      busy      <= 1'b0;
    end else begin
      // NOTE: state and registered outputs use non-blocking assignments so
      // every register samples values from before this edge.
      case (state)
        IDLE: begin
          new_data <= 1'b0;
          din      <= 8'h00;
          if (any_valid) begin
            gnt       <= pick;
            ptr       <= pick;
            lat_write <= req_write[pick];
            lat_wdata <= req_wdata[8*pick +: 8];
            // Command byte is built straight from the winning request so
            // it is on the port in the very next cycle.
            din       <= {~req_write[pick], req_addr[7*pick +: 7]};
            new_data  <= 1'b1;
            busy      <= 1'b1;
            state     <= CMD;
          end
        end

        CMD: begin
          new_data <= 1'b0;
          din      <= 8'h00;
          gap_cnt  <= GAP_LAST;
          state    <= CMD_GAP;
        end

        CMD_GAP: begin
          if (gap_cnt == 3'd0) begin
            new_data <= 1'b1;
            din      <= lat_write ? lat_wdata : 8'h00;
            state    <= DATA;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end

        DATA: begin
          new_data <= 1'b0;
          din      <= 8'h00;
          gap_cnt  <= GAP_LAST;
          state    <= DATA_GAP;
        end

        DATA_GAP: begin
          if (gap_cnt == 3'd0) begin
            // ctrlr has had the whole gap to present the read byte.
            rsp_rdata <= lat_write ? 8'h00 : dout;
            rsp_valid <= NUM_REQ'(1) << gnt;
            state     <= RESP;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end

        RESP: begin
          rsp_valid <= '0;
          rsp_rdata <= 8'h00;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          new_data  <= 1'b0;
          din       <= 8'h00;
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmio_arbiter
//   Self-checking bench for mmio_arbiter. Instance a (GAP_CYCLES=1) sits in
//   front of a behavioural ctrlr model (chip_id 0x07 at 0x00, switches at
//   0x01/0x02, leds at 0x03/0x04). Instance b (GAP_CYCLES=3) has a minimal
//   model that answers chip_id only. Expected responses go into a scoreboard
//   queue when a request is posted and are compared when rsp_valid pulses.
// -----------------------------------------------------------------------------
module tb_mmio_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // instance a
  logic [N-1:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [7:0]     rsp_rdata, din, dout;
  logic           busy, new_data;

  // instance b
  logic [N-1:0]   req_valid_b, req_write_b, req_ready_b, rsp_valid_b;
  logic [7*N-1:0] req_addr_b;
  logic [8*N-1:0] req_wdata_b;
  logic [7:0]     rsp_rdata_b, din_b, dout_b;
  logic           busy_b, new_data_b;

  mmio_arbiter #(.NUM_REQ(N), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .new_data(new_data),
    .din(din), .dout(dout)
  );

  mmio_arbiter #(.NUM_REQ(N), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_write(req_write_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .busy(busy_b), .new_data(new_data_b),
    .din(din_b), .dout(dout_b)
  );

  // ---------------- ctrlr model for instance a ----------------
  // Framing follows the arbiter reset; register contents have their own reset
  // so an abandoned frame can be shown to leave the leds untouched.
  logic        ctrl_rst_n;
  logic [15:0] leds, switches;
  logic        phase;
  logic [7:0]  cmd;

  function automatic logic [7:0] reg_rd(input logic [6:0] a, input logic [15:0] sw,
                                        input logic [15:0] ld);
    case (a)
      7'd0:    return 8'h07;
      7'd1:    return sw[7:0];
      7'd2:    return sw[15:8];
      7'd3:    return ld[7:0];
      7'd4:    return ld[15:8];
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
      cmd   <= 8'h00;
      dout  <= 8'h00;
    end else if (new_data) begin
      if (!phase) begin
        cmd   <= din;
        phase <= 1'b1;
        dout  <= din[7] ? reg_rd(din[6:0], switches, leds) : 8'h00;
      end else begin
        phase <= 1'b0;
      end
    end
  end

  always @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      leds <= 16'h0000;
    end else if (new_data && phase && !cmd[7]) begin
      case (cmd[6:0])
        7'd3:    leds[7:0]  <= din;
        7'd4:    leds[15:8] <= din;
        default: ;
      endcase
    end
  end

  // ---------------- minimal ctrlr model for instance b ----------------
  logic phase_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_b <= 1'b0;
      dout_b  <= 8'h00;
    end else if (new_data_b) begin
      phase_b <= ~phase_b;
      if (!phase_b)
        dout_b <= (din_b == 8'h80) ? 8'h07 : 8'h00;
    end
  end

  // ---------------- checking infrastructure ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         idx;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] grant_log[$];
  int         nd_count  = 0;
  int         proto_err = 0;
  logic       prev_nd   = 1'b0;
  logic       prev_nd_b = 1'b0;

  // Response scoreboard, grant log and port-rule watcher for both instances.
  always @(negedge clk) begin
    if (rst) begin
      if (req_ready != '0)
        grant_log.push_back(req_ready);
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_onehot", 32'(rsp_valid), 32'(2'(1) << sb[0].idx));
          check("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].rdata));
          void'(sb.pop_front());
        end
      end
      nd_count  <= nd_count + (new_data ? 1 : 0);
      proto_err <= proto_err
                 + ((new_data && prev_nd) ? 1 : 0)
                 + ((!new_data && din != 8'h00) ? 1 : 0)
                 + ((new_data_b && prev_nd_b) ? 1 : 0)
                 + ((!new_data_b && din_b != 8'h00) ? 1 : 0);
      prev_nd   <= new_data;
      prev_nd_b <= new_data_b;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic post(input int i, input bit wr, input logic [6:0] a, input logic [7:0] d);
    req_write[i]         = wr;
    req_addr[7*i +: 7]   = a;
    req_wdata[8*i +: 8]  = d;
    req_valid[i]         = 1'b1;
  endtask

  // Wait for the grant of requester i, then withdraw its valid.
  task automatic wait_ready(input int i, input string name);
    bit got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    check({name, "_ready"}, 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 200 && sb.size() != 0; c++)
      @(negedge clk);
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Cycle-by-cycle expectation for a single read of 0x00 with GAP_CYCLES=1.
  localparam logic       T2_ND   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [7:0] T2_DIN  [7] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic       T2_BUSY [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [1:0] T2_RDY  [7] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  typedef struct {
    int         idx;
    bit         wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd_base;
    int gl_base;
    int grants;
    bit got;

    rst         = 1'b0;
    ctrl_rst_n  = 1'b0;
    switches    = 16'h0000;
    req_valid   = '0; req_write   = '0; req_addr   = '0; req_wdata   = '0;
    req_valid_b = '0; req_write_b = '0; req_addr_b = '0; req_wdata_b = '0;

    // ---- 1. reset state, then an idle port ----
    req_valid[0] = 1'b1;           // must not be accepted while in reset
    repeat (10) @(negedge clk);
    check("rst_new_data",  32'(new_data),  32'd0);
    check("rst_din",       32'(din),       32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    req_valid  = '0;
    ctrl_rst_n = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    nd_base = nd_count;
    repeat (20) @(negedge clk);
    check("idle_new_data_count", 32'(nd_count - nd_base), 32'd0);
    check("idle_leds", 32'(leds), 32'h0000);

    // ---- 2. single read of chip_id, cycle by cycle ----
    @(posedge clk);
    #1;
    sb.push_back('{0, 8'h07});
    post(0, 1'b0, 7'h00, 8'h00);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("rd0_new_data_c%0d", c), 32'(new_data), 32'(T2_ND[c]));
      check($sformatf("rd0_din_c%0d", c), 32'(din), 32'(T2_DIN[c]));
      check($sformatf("rd0_busy_c%0d", c), 32'(busy), 32'(T2_BUSY[c]));
      check($sformatf("rd0_ready_c%0d", c), 32'(req_ready), 32'(T2_RDY[c]));
      if (c == 1) req_valid[0] = 1'b0;
    end
    check("rd0_sb_empty", 32'(sb.size()), 32'd0);

    // ---- 3. table of writes and reads through the ctrlr model ----
    vt[0] = '{1, 1'b1, 7'h03, 8'hFF, 8'h00};
    vt[1] = '{1, 1'b1, 7'h04, 8'hAA, 8'h00};
    vt[2] = '{0, 1'b0, 7'h03, 8'h00, 8'hFF};
    vt[3] = '{1, 1'b0, 7'h04, 8'h00, 8'hAA};
    vt[4] = '{0, 1'b0, 7'h01, 8'h00, 8'hFF};
    vt[5] = '{1, 1'b0, 7'h02, 8'h00, 8'h00};
    switches = 16'h00FF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{vt[i].idx, vt[i].exp});
      post(vt[i].idx, vt[i].wr, vt[i].addr, vt[i].wdata);
      wait_ready(vt[i].idx, $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
      if (i == 1) check("leds_after_writes", 32'(leds), 32'h0000AAFF);
    end

    // ---- 4. both requesters held valid: strict rotation ----
    gl_base = grant_log.size();
    sb.push_back('{0, 8'h07});
    sb.push_back('{1, 8'hFF});
    sb.push_back('{0, 8'h07});
    sb.push_back('{1, 8'hFF});
    post(0, 1'b0, 7'h00, 8'h00);
    post(1, 1'b0, 7'h03, 8'h00);
    grants = 0;
    for (int c = 0; c < 200 && grants < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) grants++;
    end
    check("rr_grant_count", 32'(grants), 32'd4);
    @(posedge clk);
    #1 req_valid = '0;
    drain("rr");
    check("rr_log_size", 32'(grant_log.size() - gl_base), 32'd4);
    if (grant_log.size() - gl_base >= 4) begin
      check("rr_grant0", 32'(grant_log[gl_base + 0]), 32'b01);
      check("rr_grant1", 32'(grant_log[gl_base + 1]), 32'b10);
      check("rr_grant2", 32'(grant_log[gl_base + 2]), 32'b01);
      check("rr_grant3", 32'(grant_log[gl_base + 3]), 32'b10);
    end

    // ---- 5. reset during the DATA beat of a write ----
    post(0, 1'b1, 7'h03, 8'h55);
    wait_ready(0, "abort");
    repeat (3) @(negedge clk);
    check("abort_in_data", 32'(new_data), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_new_data", 32'(new_data), 32'd0);
    check("abort_din",      32'(din),      32'd0);
    check("abort_busy",     32'(busy),     32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_leds", 32'(leds), 32'h0000AAFF);
    check("abort_no_rsp", 32'(sb.size()), 32'd0);

    @(posedge clk);
    #1;
    sb.push_back('{0, 8'h07});
    sb.push_back('{1, 8'hAA});
    post(0, 1'b0, 7'h00, 8'h00);
    post(1, 1'b0, 7'h04, 8'h00);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1'b1;
    end
    check("prio_after_reset", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_ready(1, "after_reset_req1");
    drain("after_reset");

    // ---- 6. GAP_CYCLES=3 instance ----
    req_write_b[0]     = 1'b0;
    req_addr_b[6:0]    = 7'h00;
    req_wdata_b[7:0]   = 8'h00;
    req_valid_b[0]     = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) check("gap3_ready", 32'(req_ready_b), 32'b01);
      check($sformatf("gap3_new_data_c%0d", c), 32'(new_data_b),
            32'((c == 1 || c == 5) ? 1 : 0));
      check($sformatf("gap3_rsp_valid_c%0d", c), 32'(rsp_valid_b),
            32'((c == 9) ? 2'b01 : 2'b00));
      if (c == 9) check("gap3_rsp_rdata", 32'(rsp_rdata_b), 32'h07);
      if (c == 1) req_valid_b[0] = 1'b0;
    end

    // ---- port rules over the whole run ----
    check("port_rules", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
